// File: rtl/window_scheduler.sv
// Strip-window scheduler: steps a 16-row window column by column through the image and handshakes fetch, blur and store units.
// Optional FILTER watchdog is enabled by defining WINDOW_SCHEDULER_WATCHDOG_EN.
module window_scheduler #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_frame_start,
  input  logic        i_abort,
  input  logic        i_fetch_ack,
  input  logic        i_blur_final,
  input  logic        i_store_ack,
  output logic        o_fetch_req,
  output logic        o_anchor_moving,
  output logic [31:0] o_anchor_x,
  output logic [31:0] o_anchor_y,
  output logic        o_store_req,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_timeout_err
);

  localparam int          STRIP_H = 16;
  localparam logic [31:0] LAST_X  = 32'(IMG_W - 1);
  localparam logic [31:0] LAST_Y  = 32'(IMG_H - STRIP_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FILTER,
    S_STORE,
    S_NEXT
  } state_t;

  state_t      r_state;
  logic [31:0] r_anchor_x;
  logic [31:0] r_anchor_y;
  logic        r_anchor_moving;
  logic        r_frame_done;
  logic        w_last_x;
  logic        w_last_col;
  logic        w_wd_expire;

  assign w_last_x   = (r_anchor_x >= LAST_X);
  assign w_last_col = w_last_x && (r_anchor_y >= LAST_Y);

`ifdef WINDOW_SCHEDULER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;

  // The TIMEOUT-th FILTER cycle without blur_final is the one that gives up.
  assign w_wd_expire = (r_state == S_FILTER) && !i_blur_final &&
                       (r_wd_cnt >= WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_FETCH && i_fetch_ack && !i_abort) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_FILTER && !i_blur_final && !w_wd_expire) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end

      if (r_state == S_IDLE && i_frame_start) begin
        r_timeout_err <= 1'b0;
      end else if (w_wd_expire && !i_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  // Watchdog compiled out; this only references TIMEOUT and is constant 0.
  assign w_wd_expire   = (TIMEOUT < 0);
  assign o_timeout_err = 1'b0;
`endif

  // NOTE: state, anchors and pulse flags all reset asynchronously so outputs drop the moment n_rst falls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_anchor_x      <= '0;
      r_anchor_y      <= '0;
      r_anchor_moving <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking assignment in the case below overrides it for one cycle.
      r_anchor_moving <= 1'b0;
      r_frame_done    <= 1'b0;

      if (i_abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_frame_start) begin
              r_state    <= S_FETCH;
              r_anchor_x <= '0;
              r_anchor_y <= '0;
            end
          end
          S_FETCH: begin
            if (i_fetch_ack) begin
              r_state         <= S_FILTER;
              r_anchor_moving <= 1'b1;
            end
          end
          S_FILTER: begin
            if (i_blur_final) begin
              r_state <= S_STORE;
            end else if (w_wd_expire) begin
              r_state <= S_IDLE;
            end
          end
          S_STORE: begin
            if (i_store_ack) begin
              r_state      <= S_NEXT;
              r_frame_done <= w_last_col;
            end
          end
          S_NEXT: begin
            if (!w_last_x) begin
              r_state    <= S_FETCH;
              r_anchor_x <= r_anchor_x + 32'd1;
            end else if (!w_last_col) begin
              r_state    <= S_FETCH;
              r_anchor_x <= '0;
              r_anchor_y <= r_anchor_y + 32'(STRIP_H);
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_fetch_req     = (r_state == S_FETCH);
  assign o_store_req     = (r_state == S_STORE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_anchor_moving = r_anchor_moving;
  assign o_frame_done    = r_frame_done;
  assign o_anchor_x      = r_anchor_x;
  assign o_anchor_y      = r_anchor_y;

endmodule

// File: tb/tb_window_scheduler.sv
// Self-checking bench for window_scheduler: random handshake delays against a column-list / cycle-count model.
module tb_window_scheduler;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 32;
  localparam int TIMEOUT = 8;
  localparam int NCOLS   = IMG_W * IMG_H / 16;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        abort = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        blur_final = 1'b0;
  logic        store_ack = 1'b0;
  logic        fetch_req, anchor_moving, store_req, busy, frame_done, timeout_err;
  logic [31:0] anchor_x, anchor_y;

  int errors = 0;
  int checks = 0;

  window_scheduler #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_frame_start  (frame_start),
    .i_abort        (abort),
    .i_fetch_ack    (fetch_ack),
    .i_blur_final   (blur_final),
    .i_store_ack    (store_ack),
    .o_fetch_req    (fetch_req),
    .o_anchor_moving(anchor_moving),
    .o_anchor_x     (anchor_x),
    .o_anchor_y     (anchor_y),
    .o_store_req    (store_req),
    .o_busy         (busy),
    .o_frame_done   (frame_done),
    .o_timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    checks++;
    if ({fetch_req, anchor_moving, store_req, busy, frame_done, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 000000", {fetch_req, anchor_moving, store_req, busy, frame_done, timeout_err});
    end
    checks++;
    if (anchor_x !== 32'd0 || anchor_y !== 32'd0) begin
      errors++;
      $display("FAIL reset_anchors got (%0d,%0d) expected (0,0)", anchor_x, anchor_y);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b fetch_req=%b expected 0 0", busy, fetch_req);
    end
  endtask

  // One whole frame; each column gets its own random fetch/blur/store wait drawn from the given ranges.
  task automatic run_frame(input string tag, input int fd_lo, input int fd_hi, input int bd_lo, input int bd_hi,
                           input int sd_lo, input int sd_hi, input bit noise);
    int fd[NCOLS];
    int bd[NCOLS];
    int sd[NCOLS];
    int ex[$];
    int ey[$];
    int total = 0;
    int cyc = 1;
    int col = -1;
    int cc = 0;
    int run = 0;
    int flcnt = 0;
    int scnt = 0;
    int mov_cnt = 0;
    int done_cnt = 0;
    bit prev_fetch = 1'b0;
    bit prev_store = 1'b0;
    bit in_filter = 1'b0;
    bit unstable = 1'b0;
    logic [31:0] hx = '0;
    logic [31:0] hy = '0;

    for (int y = 0; y < IMG_H; y += 16) begin
      for (int x = 0; x < IMG_W; x++) begin
        ex.push_back(x);
        ey.push_back(y);
      end
    end
    for (int c = 0; c < NCOLS; c++) begin
      fd[c] = $urandom_range(fd_hi, fd_lo);
      bd[c] = $urandom_range(bd_hi, bd_lo);
      sd[c] = $urandom_range(sd_hi, sd_lo);
      total += fd[c] + bd[c] + sd[c] + 4;
    end

    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;

    while (cyc <= total) begin
      if (fetch_req && !prev_fetch) begin
        col++;
        run = 0;
        hx = anchor_x;
        hy = anchor_y;
        checks++;
        if (col >= NCOLS) begin
          errors++;
          $display("FAIL %s column_count got column %0d expected at most %0d", tag, col, NCOLS - 1);
        end else if (anchor_x !== 32'(ex[col]) || anchor_y !== 32'(ey[col])) begin
          errors++;
          $display("FAIL %s anchor_col%0d got (%0d,%0d) expected (%0d,%0d)", tag, col, anchor_x, anchor_y, ex[col], ey[col]);
        end
      end
      cc = (col < 0) ? 0 : ((col >= NCOLS) ? NCOLS - 1 : col);

      if (fetch_req) begin
        if (anchor_x !== hx || anchor_y !== hy) unstable = 1'b1;
        run++;
        fetch_ack = (run > fd[cc]);
      end else begin
        fetch_ack = 1'b0;
      end

      if (prev_fetch && !fetch_req) begin
        checks++;
        if (run !== fd[cc] + 1) begin
          errors++;
          $display("FAIL %s fetch_len_col%0d got %0d expected %0d", tag, col, run, fd[cc] + 1);
        end
        checks++;
        if (anchor_moving !== 1'b1) begin
          errors++;
          $display("FAIL %s anchor_moving_col%0d got %b expected 1", tag, col, anchor_moving);
        end
        in_filter = 1'b1;
        flcnt = 0;
      end
      if (anchor_moving) mov_cnt++;

      if (in_filter) begin
        blur_final = (flcnt >= bd[cc]);
        flcnt++;
        if (blur_final) in_filter = 1'b0;
      end else begin
        blur_final = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end

      if (store_req) begin
        if (!prev_store) scnt = 0;
        if (anchor_x !== hx || anchor_y !== hy) unstable = 1'b1;
        scnt++;
        store_ack = (scnt > sd[cc]);
      end else begin
        store_ack = 1'b0;
      end

      if (frame_done) begin
        done_cnt++;
        checks++;
        if (cyc != total) begin
          errors++;
          $display("FAIL %s frame_done_cycle got %0d expected %0d", tag, cyc, total);
        end
      end

      frame_start = (noise && busy && cyc < total) ? ($urandom_range(7, 0) == 0) : 1'b0;
      prev_fetch = fetch_req;
      prev_store = store_req;
      cyc++;
      @(negedge clk);
    end

    fetch_ack   = 1'b0;
    blur_final  = 1'b0;
    store_ack   = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done got busy=%b frame_done=%b expected 0 0", tag, busy, frame_done);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s frame_done_pulses got %0d expected 1", tag, done_cnt);
    end
    checks++;
    if (col != NCOLS - 1 || mov_cnt != NCOLS) begin
      errors++;
      $display("FAIL %s columns got %0d moving_pulses %0d expected %0d", tag, col + 1, mov_cnt, NCOLS);
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL %s anchor_stable got changing anchor expected stable while requesting", tag);
    end
  endtask

  task automatic test_tied_high();
    run_frame("tied_high", 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_fetch_delay();
    run_frame("fetch_delay5", 5, 5, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_start_in_filter();
    run_frame("start_ignored", 0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    repeat (3) run_frame("random", 0, 3, 0, 5, 0, 3, 1'b1);
  endtask

  task automatic test_abort();
    int n = 0;
    int bad = 0;
    bit found = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fetch_ack  = 1'b1;
    blur_final = 1'b1;
    store_ack  = 1'b1;
    while (n < 100 && !found) begin
      if (frame_done) bad++;
      if (fetch_req && anchor_x == 32'd2 && anchor_y == 32'd16) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach_col got no FETCH at (2,16) expected one within 100 cycles");
    end
    abort = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    fetch_ack  = 1'b0;
    blur_final = 1'b0;
    store_ack  = 1'b0;
    checks++;
    if ({busy, fetch_req, store_req, anchor_moving} !== 4'b0) begin
      errors++;
      $display("FAIL abort_idle got busy/fetch/store/moving=%b expected 0000", {busy, fetch_req, store_req, anchor_moving});
    end
    checks++;
    if (anchor_x !== 32'd2 || anchor_y !== 32'd16) begin
      errors++;
      $display("FAIL abort_anchor_hold got (%0d,%0d) expected (2,16)", anchor_x, anchor_y);
    end
    repeat (6) begin
      @(negedge clk);
      if (frame_done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d done/busy cycles expected 0", bad);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (fetch_req !== 1'b1 || anchor_x !== 32'd0 || anchor_y !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart got fetch_req=%b (%0d,%0d) expected 1 (0,0)", fetch_req, anchor_x, anchor_y);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fetch_ack  = 1'b1;
    blur_final = 1'b1;
    store_ack  = 1'b0;
    while (n < 20 && !store_req) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (store_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach_store got store_req=%b expected 1 within 20 cycles", store_req);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({fetch_req, anchor_moving, store_req, busy, frame_done, timeout_err} !== 6'b0 ||
        anchor_x !== 32'd0 || anchor_y !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async got flags=%b (%0d,%0d) expected 000000 (0,0)",
               {fetch_req, anchor_moving, store_req, busy, frame_done, timeout_err}, anchor_x, anchor_y);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_resume got busy=%b fetch_req=%b expected 0 0", busy, fetch_req);
    end
    fetch_ack  = 1'b0;
    blur_final = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (fetch_req !== 1'b1 || anchor_x !== 32'd0 || anchor_y !== 32'd0) begin
      errors++;
      $display("FAIL midreset_restart got fetch_req=%b (%0d,%0d) expected 1 (0,0)", fetch_req, anchor_x, anchor_y);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

`ifdef WINDOW_SCHEDULER_WATCHDOG_EN
  task automatic test_watchdog();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fetch_ack   = 1'b1;
    blur_final  = 1'b0;
    @(negedge clk);
    fetch_ack = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_before_expiry got busy=%b timeout_err=%b expected 1 0", busy, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_expiry got busy=%b timeout_err=%b frame_done=%b expected 0 1 0", busy, timeout_err, frame_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky got %b expected 1", timeout_err);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_clear got timeout_err=%b busy=%b expected 0 1", timeout_err, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask
`else
  task automatic test_no_watchdog();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fetch_ack   = 1'b1;
    blur_final  = 1'b0;
    @(negedge clk);
    fetch_ack = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || store_req !== 1'b0) begin
      errors++;
      $display("FAIL filter_wait got busy=%b timeout_err=%b store_req=%b expected 1 0 0", busy, timeout_err, store_req);
    end
    blur_final = 1'b1;
    @(negedge clk);
    blur_final = 1'b0;
    checks++;
    if (store_req !== 1'b1) begin
      errors++;
      $display("FAIL filter_release got store_req=%b expected 1", store_req);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout got no summary expected completion before 500000 time units");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_tied_high();
    test_fetch_delay();
    test_start_in_filter();
    test_random();
    test_abort();
    test_reset_midframe();
`ifdef WINDOW_SCHEDULER_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 Parameter IMG_W, default 640, image width in pixels (columns per strip).
REQ-002 Parameter IMG_H, default 480, image height in pixels; SHALL be a multiple of 16.
REQ-003 Parameter TIMEOUT, default 1023, max cycles waited for blur_final (used only with macro, REQ-031).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  single-cycle request to process one full frame.
REQ-007 abort  input  1  synchronous cancel of the frame in progress.
REQ-008 fetch_ack  input  1  fetch unit has loaded the 20-pixel input column into blur_in.
REQ-009 blur_final  input  1  blur controller finished the current column.
REQ-010 store_ack  input  1  writer has taken the 16-pixel blur_out column.
REQ-011 fetch_req  output  1  level request to fetch column at (anchor_x, anchor_y).
REQ-012 anchor_moving  output  1  one-cycle start pulse to blur controller.
REQ-013 anchor_x  output  32  current window column, 0..IMG_W-1.
REQ-014 anchor_y  output  32  current strip top row, multiple of 16, 0..IMG_H-16.
REQ-015 store_req  output  1  level request to store blur_out column.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 frame_done  output  1  one-cycle pulse after last column stored.
REQ-018 timeout_err  output  1  sticky watchdog flag (tied 0 without macro).

Function
REQ-019 FSM states SHALL be IDLE, FETCH, FILTER, STORE, NEXT.
REQ-020 IDLE: frame_start=1 -> FETCH next cycle, anchor_x=0, anchor_y=0; frame_start outside IDLE ignored.
REQ-021 FETCH: fetch_req=1 (combinational from state); fetch_ack=1 -> FILTER, anchor_moving=1 during the first FILTER cycle only.
REQ-022 FILTER: wait for blur_final=1 -> STORE; blur_final outside FILTER ignored.
REQ-023 STORE: store_req=1; store_ack=1 -> NEXT.
REQ-024 NEXT (one cycle): anchor_x<IMG_W-1 -> anchor_x+1, FETCH; else anchor_x=0 and anchor_y+16 -> FETCH, unless anchor_y==IMG_H-16 -> IDLE with frame_done=1 in that same NEXT cycle.
REQ-025 anchor_x/anchor_y SHALL be registered and change only on NEXT->FETCH or IDLE->FETCH transitions; stable while fetch_req or store_req high.
REQ-026 Column order: raster within strip (x ascending), strips top to bottom; total IMG_W*IMG_H/16 FETCH->STORE sequences per frame.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle; fetch_req/store_req drop, no frame_done, anchors hold their last value; abort wins over simultaneous acks.
REQ-028 Acks arriving in the same cycle as state entry SHALL be honoured (zero-wait handshake); minimum per-column cycle count is 4 (FETCH, FILTER, STORE, NEXT).

Reset
REQ-029 n_rst=0 SHALL force IDLE, anchor_x=0, anchor_y=0, all request/pulse outputs 0, busy=0, timeout_err=0, watchdog count 0.
REQ-030 Reset mid-frame discards progress; a new frame_start is required after release.

Configuration
REQ-031 Macro WINDOW_SCHEDULER_WATCHDOG_EN defined: counter cleared on FILTER entry, increments each FILTER cycle; reaching TIMEOUT without blur_final -> timeout_err=1, state IDLE, no frame_done; timeout_err clears on next accepted frame_start.
REQ-032 Macro undefined: no watchdog logic, FILTER waits indefinitely, timeout_err tied 0.

Verification (IMG_W=4, IMG_H=32 unless stated)
REQ-033 Reset, frame_start pulse, acks and blur_final tied high -> 8 columns, anchors (0,0)(1,0)(2,0)(3,0)(0,16)..(3,16), frame_done single pulse 32 cycles after FETCH entry, busy low next cycle.
REQ-034 fetch_ack delayed 5 cycles per column -> fetch_req held 6 cycles each, anchor_x unchanged throughout, exactly 8 anchor_moving pulses.
REQ-035 abort asserted with fetch_ack in FETCH at (2,16) -> IDLE next cycle, no anchor_moving, no frame_done; next frame_start restarts at (0,0).
REQ-036 frame_start pulsed during FILTER -> ignored; column count and frame_done timing identical to REQ-033.
REQ-037 Macro on, TIMEOUT=8, blur_final held 0 -> timeout_err=1 after 8 FILTER cycles, busy=0, frame_done never; frame_start clears timeout_err.
REQ-038 n_rst asserted while store_req high -> all outputs 0 immediately (async), IDLE after release.
